// File: rtl/tcm_port_arbiter.sv
// ----------------------------------------------------------------------------
// tcm_port_arbiter
//
// Shares one synchronous single-port TCM RAM between the CPU data port and an
// AXI4-Lite slave (separate write and read channels). At most one requester is
// granted per cycle; the grant drives the RAM port combinationally and the
// completion (cpu ack, AXI B, AXI R) appears one cycle later.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cpu_req_i/cpu_wr_i           CPU request, write when cpu_wr_i
//   cpu_addr_i/wdata_i/wstrb_i   CPU byte address, write data, byte strobes
//   cpu_ack_o/cpu_rdata_o        one-cycle completion pulse, read data
//   axi_aw*/axi_w*/axi_b*        AXI4-Lite write address/data/response
//   axi_ar*/axi_r*               AXI4-Lite read address/data
//   ram_en_o/ram_wr_o            RAM enable, per-byte write enables
//   ram_addr_o/ram_wdata_o       RAM word address, write data
//   ram_rdata_i                  RAM read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module tcm_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // CPU data port
   input  logic              cpu_req_i,
   input  logic              cpu_wr_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   input  logic [3:0]        cpu_wstrb_i,
   output logic              cpu_ack_o,
   output logic [31:0]       cpu_rdata_o,
   // AXI4-Lite write address / data / response
   input  logic              axi_awvalid_i,
   input  logic [31:0]       axi_awaddr_i,
   output logic              axi_awready_o,
   input  logic              axi_wvalid_i,
   input  logic [31:0]       axi_wdata_i,
   input  logic [3:0]        axi_wstrb_i,
   output logic              axi_wready_o,
   output logic              axi_bvalid_o,
   input  logic              axi_bready_i,
   // AXI4-Lite read address / data
   input  logic              axi_arvalid_i,
   input  logic [31:0]       axi_araddr_i,
   output logic              axi_arready_o,
   output logic              axi_rvalid_o,
   output logic [31:0]       axi_rdata_o,
   input  logic              axi_rready_i,
   // RAM port
   output logic              ram_en_o,
   output logic [3:0]        ram_wr_o,
   output logic [ADDR_W-3:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   typedef enum logic [1:0] {
      GNT_NONE   = 2'd0,
      GNT_CPU    = 2'd1,
      GNT_AXI_WR = 2'd2,
      GNT_AXI_RD = 2'd3
   } gnt_e;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   gnt_e        gnt_s;
   logic        wr_elig_s;
   logic        rd_elig_s;
   logic        axi_elig_s;
   logic        axi_forced_s;

   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        rr_rd_q,      rr_rd_d;      // 1: read favoured on a tie
   logic        cpu_ack_q,    cpu_ack_d;
   logic        cpu_rd_q,     cpu_rd_d;     // pending ack belongs to a read
   logic        bvalid_q,     bvalid_d;
   logic        rvalid_q,     rvalid_d;
   logic        rd_first_q,   rd_first_d;   // RAM data is on ram_rdata_i now
   logic [31:0] rdata_q,      rdata_d;

   // Address bits outside the TCM window and the byte offset are ignored.
   logic unused_addr_s;
   assign unused_addr_s = ^{cpu_addr_i[31:ADDR_W], cpu_addr_i[1:0],
                            axi_awaddr_i[31:ADDR_W], axi_awaddr_i[1:0],
                            axi_araddr_i[31:ADDR_W], axi_araddr_i[1:0]};

   // Arbitration: CPU first unless a starving AXI request is forced through.
   always_comb begin
      gnt_s        = GNT_NONE;
      wr_elig_s    = axi_awvalid_i && axi_wvalid_i && !bvalid_q;
      rd_elig_s    = axi_arvalid_i && !rvalid_q;
      axi_elig_s   = wr_elig_s || rd_elig_s;
      axi_forced_s = (starve_cnt_q == STARVE_MAX);
      if (rst_i) begin
         // No RAM access and no ready while reset is applied.
         gnt_s = GNT_NONE;
      end else if (axi_elig_s && (!cpu_req_i || axi_forced_s)) begin
         if (wr_elig_s && rd_elig_s) begin
            gnt_s = rr_rd_q ? GNT_AXI_RD : GNT_AXI_WR;
         end else if (wr_elig_s) begin
            gnt_s = GNT_AXI_WR;
         end else begin
            gnt_s = GNT_AXI_RD;
         end
      end else if (cpu_req_i) begin
         gnt_s = GNT_CPU;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // RAM port and channel readies driven from the winner.
   always_comb begin
      ram_en_o      = 1'b0;
      ram_wr_o      = 4'b0000;
      ram_addr_o    = '0;
      ram_wdata_o   = 32'h0000_0000;
      axi_awready_o = 1'b0;
      axi_wready_o  = 1'b0;
      axi_arready_o = 1'b0;
      case (gnt_s)
         GNT_CPU: begin
            ram_en_o    = 1'b1;
            ram_wr_o    = cpu_wr_i ? cpu_wstrb_i : 4'b0000;
            ram_addr_o  = cpu_addr_i[ADDR_W-1:2];
            ram_wdata_o = cpu_wdata_i;
         end
         GNT_AXI_WR: begin
            ram_en_o      = 1'b1;
            ram_wr_o      = axi_wstrb_i;
            ram_addr_o    = axi_awaddr_i[ADDR_W-1:2];
            ram_wdata_o   = axi_wdata_i;
            axi_awready_o = 1'b1;
            axi_wready_o  = 1'b1;
         end
         GNT_AXI_RD: begin
            ram_en_o      = 1'b1;
            ram_addr_o    = axi_araddr_i[ADDR_W-1:2];
            axi_arready_o = 1'b1;
         end
         default: begin
            ram_en_o = 1'b0;
         end
      endcase
   end

   // Completion, response and fairness state for the next cycle.
   always_comb begin
      cpu_ack_d    = (gnt_s == GNT_CPU);
      cpu_rd_d     = (gnt_s == GNT_CPU) && !cpu_wr_i;
      rd_first_d   = (gnt_s == GNT_AXI_RD);
      rr_rd_d      = rr_rd_q;
      bvalid_d     = bvalid_q;
      rvalid_d     = rvalid_q;
      rdata_d      = rdata_q;
      starve_cnt_d = starve_cnt_q;

      if (gnt_s == GNT_AXI_WR) begin
         bvalid_d = 1'b1;
      end else if (axi_bready_i) begin
         bvalid_d = 1'b0;
      end else begin
         bvalid_d = bvalid_q;
      end

      if (gnt_s == GNT_AXI_RD) begin
         rvalid_d = 1'b1;
      end else if (axi_rready_i) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end

      // RAM data is only present for one cycle; keep it while R is stalled.
      if (rd_first_q) begin
         rdata_d = ram_rdata_i;
      end else begin
         rdata_d = rdata_q;
      end

      if (gnt_s == GNT_AXI_WR) begin
         rr_rd_d = 1'b1;
      end else if (gnt_s == GNT_AXI_RD) begin
         rr_rd_d = 1'b0;
      end else begin
         rr_rd_d = rr_rd_q;
      end

      if ((gnt_s == GNT_AXI_WR) || (gnt_s == GNT_AXI_RD)) begin
         starve_cnt_d = 4'd0;
      end else if (axi_elig_s && (gnt_s == GNT_CPU) && (starve_cnt_q < STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // State registers, cleared asynchronously by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt_q <= 4'd0;
         rr_rd_q      <= 1'b0;
         cpu_ack_q    <= 1'b0;
         cpu_rd_q     <= 1'b0;
         bvalid_q     <= 1'b0;
         rvalid_q     <= 1'b0;
         rd_first_q   <= 1'b0;
         rdata_q      <= 32'h0000_0000;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rr_rd_q      <= rr_rd_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_rd_q     <= cpu_rd_d;
         bvalid_q     <= bvalid_d;
         rvalid_q     <= rvalid_d;
         rd_first_q   <= rd_first_d;
         rdata_q      <= rdata_d;
      end
   end

   assign cpu_ack_o    = cpu_ack_q;
   assign cpu_rdata_o  = cpu_rd_q ? ram_rdata_i : 32'h0000_0000;
   assign axi_bvalid_o = bvalid_q;
   assign axi_rvalid_o = rvalid_q;
   assign axi_rdata_o  = rd_first_q ? ram_rdata_i : rdata_q;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tcm_port_arbiter
//
// Directed bench for tcm_port_arbiter. A tiny RAM stand-in returns
// 0xDEADBEEF ^ word_address the cycle after a read and 0x0BAD0BAD otherwise,
// so every expected read value can be written down by hand.
// ----------------------------------------------------------------------------
module tb_tcm_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_i, cpu_wr_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i;
   logic [3:0]  cpu_wstrb_i;
   logic        cpu_ack_o;
   logic [31:0] cpu_rdata_o;
   logic        axi_awvalid_i, axi_awready_o;
   logic [31:0] axi_awaddr_i;
   logic        axi_wvalid_i, axi_wready_o;
   logic [31:0] axi_wdata_i;
   logic [3:0]  axi_wstrb_i;
   logic        axi_bvalid_o, axi_bready_i;
   logic        axi_arvalid_i, axi_arready_o;
   logic [31:0] axi_araddr_i;
   logic        axi_rvalid_o, axi_rready_i;
   logic [31:0] axi_rdata_o;
   logic        ram_en_o;
   logic [3:0]  ram_wr_o;
   logic [13:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i = 32'h0BAD_0BAD;

   int n_cmp = 0;
   int n_err = 0;

   tcm_port_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_wstrb_i(cpu_wstrb_i),
      .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
      .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awready_o(axi_awready_o),
      .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
      .axi_wready_o(axi_wready_o), .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
      .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arready_o(axi_arready_o),
      .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rready_i(axi_rready_i),
      .ram_en_o(ram_en_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // RAM stand-in: pattern data one cycle after a read, filler otherwise.
   always @(posedge clk_i) begin
      if (ram_en_o && (ram_wr_o == 4'b0000)) begin
         ram_rdata_i <= 32'hDEAD_BEEF ^ {18'h0, ram_addr_o};
      end else begin
         ram_rdata_i <= 32'h0BAD_0BAD;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0;
      cpu_wstrb_i = 4'b0000;
      axi_awvalid_i = 1'b0; axi_awaddr_i = 32'h0; axi_wvalid_i = 1'b0;
      axi_wdata_i = 32'h0; axi_wstrb_i = 4'b0000; axi_bready_i = 1'b0;
      axi_arvalid_i = 1'b0; axi_araddr_i = 32'h0; axi_rready_i = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst_i = 1'b1;
      tick(); tick();
      // Reset state
      check_eq("rst_ram_en", {31'h0, ram_en_o}, 32'h0);
      check_eq("rst_ram_wr", {28'h0, ram_wr_o}, 32'h0);
      check_eq("rst_readies", {29'h0, axi_awready_o, axi_wready_o, axi_arready_o}, 32'h0);
      check_eq("rst_valids", {29'h0, cpu_ack_o, axi_bvalid_o, axi_rvalid_o}, 32'h0);
      check_eq("rst_rdata", axi_rdata_o, 32'h0);
      rst_i = 1'b0;

      // CPU read of byte address 0x10 -> word 4
      cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0010;
      #1;
      check_eq("cpu_rd_en", {31'h0, ram_en_o}, 32'h1);
      check_eq("cpu_rd_addr", {18'h0, ram_addr_o}, 32'h4);
      check_eq("cpu_rd_wr", {28'h0, ram_wr_o}, 32'h0);
      tick();
      cpu_req_i = 1'b0;
      #1;
      check_eq("cpu_rd_ack", {31'h0, cpu_ack_o}, 32'h1);
      check_eq("cpu_rd_data", cpu_rdata_o, 32'hDEAD_BEEB);
      tick();
      check_eq("cpu_ack_pulse", {31'h0, cpu_ack_o}, 32'h0);

      // Back-to-back CPU reads: 0x0 then 0x8
      cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0000;
      tick();
      cpu_addr_i = 32'hFFFF_0008;   // upper bits ignored
      #1;
      check_eq("b2b_ack1", {31'h0, cpu_ack_o}, 32'h1);
      check_eq("b2b_data1", cpu_rdata_o, 32'hDEAD_BEEF);
      check_eq("b2b_addr2", {18'h0, ram_addr_o}, 32'h2);
      tick();
      cpu_req_i = 1'b0;
      #1;
      check_eq("b2b_ack2", {31'h0, cpu_ack_o}, 32'h1);
      check_eq("b2b_data2", cpu_rdata_o, 32'hDEAD_BEED);
      tick();

      // CPU write with zero strobe still occupies the port and is acked
      cpu_req_i = 1'b1; cpu_wr_i = 1'b1; cpu_addr_i = 32'h0000_0020;
      cpu_wdata_i = 32'hCAFE_F00D; cpu_wstrb_i = 4'b0000;
      #1;
      check_eq("cpu_wr0_en", {31'h0, ram_en_o}, 32'h1);
      check_eq("cpu_wr0_addr", {18'h0, ram_addr_o}, 32'h8);
      check_eq("cpu_wr0_wdata", ram_wdata_o, 32'hCAFE_F00D);
      tick();
      cpu_req_i = 1'b0; cpu_wr_i = 1'b0;
      #1;
      check_eq("cpu_wr0_ack", {31'h0, cpu_ack_o}, 32'h1);
      check_eq("cpu_wr0_rdata", cpu_rdata_o, 32'h0);
      tick();

      // AXI write 0x104 with backpressure on B
      axi_awvalid_i = 1'b1; axi_awaddr_i = 32'h0000_0104;
      axi_wvalid_i = 1'b1; axi_wdata_i = 32'h1234_5678; axi_wstrb_i = 4'b0011;
      #1;
      check_eq("axw_ready", {30'h0, axi_awready_o, axi_wready_o}, 32'h3);
      check_eq("axw_addr", {18'h0, ram_addr_o}, 32'h41);
      check_eq("axw_strb", {28'h0, ram_wr_o}, 32'h3);
      check_eq("axw_wdata", ram_wdata_o, 32'h1234_5678);
      tick();
      axi_awaddr_i = 32'h0000_0108; axi_wdata_i = 32'hA5A5_5A5A; axi_wstrb_i = 4'b1111;
      #1;
      check_eq("axw_bvalid", {31'h0, axi_bvalid_o}, 32'h1);
      check_eq("axw_blocked", {30'h0, axi_awready_o, ram_en_o}, 32'h0);
      tick();
      check_eq("axw_bhold", {31'h0, axi_bvalid_o}, 32'h1);
      axi_bready_i = 1'b1;
      #1;
      check_eq("axw_hs_noready", {31'h0, axi_awready_o}, 32'h0);
      tick();
      check_eq("axw_bclr", {31'h0, axi_bvalid_o}, 32'h0);
      check_eq("axw2_ready", {31'h0, axi_awready_o}, 32'h1);
      check_eq("axw2_addr", {18'h0, ram_addr_o}, 32'h42);
      tick();
      axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
      #1;
      check_eq("axw2_bvalid", {31'h0, axi_bvalid_o}, 32'h1);
      tick();
      check_eq("axw2_bdone", {31'h0, axi_bvalid_o}, 32'h0);
      axi_bready_i = 1'b0;

      // AXI read of word 0 held with rready low, then reset mid-read
      axi_arvalid_i = 1'b1; axi_araddr_i = 32'h0000_0000;
      #1;
      check_eq("axr_ready", {31'h0, axi_arready_o}, 32'h1);
      tick();
      axi_arvalid_i = 1'b0;
      #1;
      check_eq("axr_rvalid", {31'h0, axi_rvalid_o}, 32'h1);
      check_eq("axr_rdata", axi_rdata_o, 32'hDEAD_BEEF);
      tick();
      check_eq("axr_rdata_hold", axi_rdata_o, 32'hDEAD_BEEF);
      cpu_req_i = 1'b1; axi_arvalid_i = 1'b1;
      rst_i = 1'b1;
      #1;
      check_eq("mid_rst_rvalid", {31'h0, axi_rvalid_o}, 32'h0);
      check_eq("mid_rst_rdata", axi_rdata_o, 32'h0);
      check_eq("mid_rst_port", {28'h0, ram_en_o, axi_awready_o, axi_wready_o, axi_arready_o}, 32'h0);
      tick(); tick();
      idle_inputs();
      rst_i = 1'b0;
      #1;
      check_eq("post_rst_idle", {31'h0, ram_en_o}, 32'h0);
      tick();
      check_eq("post_rst_noack", {29'h0, cpu_ack_o, axi_bvalid_o, axi_rvalid_o}, 32'h0);

      // Write/read alternation from reset, both channels always pending
      axi_awvalid_i = 1'b1; axi_awaddr_i = 32'h0000_000C; axi_wvalid_i = 1'b1;
      axi_wdata_i = 32'h0000_1111; axi_wstrb_i = 4'b1111;
      axi_arvalid_i = 1'b1; axi_araddr_i = 32'h0000_0030;
      axi_bready_i = 1'b1; axi_rready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("alt_%0d", i), {30'h0, axi_awready_o, axi_arready_o},
                  (i % 2 == 0) ? 32'h2 : 32'h1);
         tick();
      end
      idle_inputs();
      axi_bready_i = 1'b1; axi_rready_i = 1'b1;
      tick(); tick();

      // Starvation: CPU read held, AXI read pending, limit 4
      cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0040;
      axi_arvalid_i = 1'b1; axi_araddr_i = 32'h0000_0050;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("starve_cpu_%0d", i), {17'h0, axi_arready_o, ram_addr_o},
                  32'h0000_0010);
         tick();
      end
      #1;
      check_eq("starve_axi_grant", {17'h0, axi_arready_o, ram_addr_o}, 32'h0000_4014);
      check_eq("starve_ack5", {31'h0, cpu_ack_o}, 32'h1);
      tick();
      axi_arvalid_i = 1'b0;
      #1;
      check_eq("starve_noack6", {31'h0, cpu_ack_o}, 32'h0);
      check_eq("starve_rvalid", {31'h0, axi_rvalid_o}, 32'h1);
      check_eq("starve_rdata", axi_rdata_o, 32'hDEAD_BEFB);
      check_eq("starve_cpu_resume", {17'h0, axi_arready_o, ram_addr_o}, 32'h0000_0010);
      tick();
      cpu_req_i = 1'b0;
      #1;
      check_eq("starve_ack7", {31'h0, cpu_ack_o}, 32'h1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
